// File: rtl/clk_tick_pkg.sv
// clk_tick_pkg: shared constants, channel-index width helper and channel config record
package clk_tick_pkg;
    localparam int CNT_W = 32;
    localparam int DEFAULT_DIV = 100_000_000;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [CNT_W-1:0] div;
        logic             oneshot;
    } chan_cfg_t;
endpackage

// File: rtl/clk_tick_chan.sv
// clk_tick_chan: one timebase channel with counter, armed flag and registered tick/clk_out
module clk_tick_chan #(
    parameter int               CNT_W       = clk_tick_pkg::CNT_W,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(clk_tick_pkg::DEFAULT_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_div_i,
    input  logic             wr_oneshot_i,
    input  logic             restart_i,
    output logic             tick_o,
    output logic             clk_out_o
);
    logic [CNT_W-1:0] div_q, div_d, count_q, count_d;
    logic oneshot_q, oneshot_d, armed_q, armed_d, tick_q, tick_d, clk_out_q, clk_out_d;
    logic adv, wrap, rearm, div_nz;

    always_comb begin
        div_nz    = div_q != '0;
        adv       = en_i && armed_q && div_nz;
        wrap      = adv && (count_q == div_q - CNT_W'(1));
        rearm     = wr_i || restart_i;
        div_d     = wr_i ? wr_div_i : div_q;
        oneshot_d = wr_i ? wr_oneshot_i : oneshot_q;
        armed_d   = rearm || (armed_q && !(wrap && oneshot_q));
        count_d   = (rearm || wrap) ? '0 : adv ? count_q + CNT_W'(1) : count_q;
        tick_d    = wrap && !rearm;
        // high phase is the last floor(div/2) counts of the period
        clk_out_d = !div_nz ? 1'b0 : !en_i ? clk_out_q : (count_q >= div_q - (div_q >> 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= DEFAULT_DIV;
            oneshot_q <= 1'b0;
            armed_q   <= 1'b1;
            count_q   <= '0;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            oneshot_q <= oneshot_d;
            armed_q   <= armed_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign tick_o    = tick_q;
    assign clk_out_o = clk_out_q;
endmodule

// File: rtl/clk_tick_gen.sv
// clk_tick_gen: NUM_CH independent programmable tick/square-wave timebases
module clk_tick_gen #(
    parameter int               NUM_CH      = 4,
    parameter int               CNT_W       = clk_tick_pkg::CNT_W,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(clk_tick_pkg::DEFAULT_DIV),
    localparam int              CH_W        = clk_tick_pkg::ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_oneshot,
    output logic              cfg_ack,
    output logic              cfg_err,
    input  logic [NUM_CH-1:0] restart,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);
    import clk_tick_pkg::*;

    localparam int NSEL = 2 ** CH_W;
    // one bit per encodable index, set for indices that name a real channel
    localparam logic [NSEL-1:0] CH_OK = {NSEL{1'b1}} >> (NSEL - NUM_CH);

    logic cfg_ok, cfg_ack_q, cfg_ack_d, cfg_err_q, cfg_err_d;

    always_comb begin
        cfg_ok    = CH_OK[cfg_ch];
        cfg_ack_d = cfg_we && cfg_ok;
        cfg_err_d = cfg_we && !cfg_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ack_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_ack_q <= cfg_ack_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_ack = cfg_ack_q;
    assign cfg_err = cfg_err_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clk_tick_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .en_i         (en),
            .wr_i         (cfg_ack_d && (cfg_ch == CH_W'(c))),
            .wr_div_i     (cfg_div),
            .wr_oneshot_i (cfg_oneshot),
            .restart_i    (restart[c]),
            .tick_o       (tick[c]),
            .clk_out_o    (clk_out[c])
        );
    end
endmodule

// File: tb/tb_clk_tick_gen.sv
// tb_clk_tick_gen: directed and random stimulus checked against an elapsed-time model
module tb_clk_tick_gen;
    localparam int N   = 5;
    localparam int W   = 16;
    localparam int DD  = 10;
    localparam int CHW = 3;

    logic           clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic           cfg_we = 1'b0, cfg_oneshot = 1'b0;
    logic [CHW-1:0] cfg_ch = '0;
    logic [W-1:0]   cfg_div = '0;
    logic [N-1:0]   restart = '0;
    logic           cfg_ack, cfg_err;
    logic [N-1:0]   tick, clk_out;

    int checks = 0, errors = 0;
    int tick_cnt[N];

    int     m_div[N];
    bit     m_os[N], m_arm[N], m_tick[N], m_clk[N];
    longint m_e[N];
    bit     m_ack = 1'b0, m_err = 1'b0;

    always #5 clk = ~clk;

    clk_tick_gen #(.NUM_CH(N), .CNT_W(W), .DEFAULT_DIV(W'(DD))) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot), .cfg_ack(cfg_ack),
        .cfg_err(cfg_err), .restart(restart), .tick(tick), .clk_out(clk_out)
    );

    // model: m_e counts enabled, armed cycles since arming; phase is m_e mod div
    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_ack = 0;
            m_err = 0;
            for (int i = 0; i < N; i++) begin
                m_div[i] = DD; m_os[i] = 0; m_arm[i] = 1; m_e[i] = 0; m_tick[i] = 0; m_clk[i] = 0;
            end
        end else begin
            m_ack = cfg_we && (int'(cfg_ch) < N);
            m_err = cfg_we && (int'(cfg_ch) >= N);
            for (int i = 0; i < N; i++) begin
                bit wr;
                wr = m_ack && (int'(cfg_ch) == i);
                if (m_div[i] == 0) m_clk[i] = 0;
                else if (en) m_clk[i] = (m_e[i] % m_div[i]) >= longint'((m_div[i] + 1) / 2);
                if (wr || restart[i]) begin
                    if (wr) begin m_div[i] = int'(cfg_div); m_os[i] = cfg_oneshot; end
                    m_e[i] = 0; m_arm[i] = 1; m_tick[i] = 0;
                end else if (en && m_arm[i] && m_div[i] != 0) begin
                    m_e[i]++;
                    m_tick[i] = (m_e[i] % m_div[i]) == 0;
                    if (m_tick[i] && m_os[i]) m_arm[i] = 0;
                end else m_tick[i] = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                checks += 2;
                assert (tick[i] === m_tick[i]) else begin
                    errors++;
                    $error("FAIL tick[%0d] got %b exp %b at %0t", i, tick[i], m_tick[i], $time);
                end
                assert (clk_out[i] === m_clk[i]) else begin
                    errors++;
                    $error("FAIL clk_out[%0d] got %b exp %b at %0t", i, clk_out[i], m_clk[i], $time);
                end
                tick_cnt[i] += int'(tick[i] === 1'b1);
            end
            checks += 2;
            assert (cfg_ack === m_ack) else begin
                errors++;
                $error("FAIL cfg_ack got %b exp %b at %0t", cfg_ack, m_ack, $time);
            end
            assert (cfg_err === m_err) else begin
                errors++;
                $error("FAIL cfg_err got %b exp %b at %0t", cfg_err, m_err, $time);
            end
        end
    endtask

    task automatic cfg(input int ch, input int d, input bit os);
        cfg_we = 1; cfg_ch = CHW'(ch); cfg_div = W'(d); cfg_oneshot = os;
        step(1);
        cfg_we = 0;
    endtask

    task automatic pulse_restart(input int ch);
        restart[ch] = 1'b1;
        step(1);
        restart = '0;
    endtask

    task automatic expect_ticks(input int ch, input int exp, input string tag);
        checks++;
        assert (tick_cnt[ch] == exp) else begin
            errors++;
            $error("FAIL %s tick count got %0d exp %0d", tag, tick_cnt[ch], exp);
        end
    endtask

    initial begin
        en = 1;
        step(3);
        rst = 0;
        tick_cnt = '{default: 0};
        step(35);
        expect_ticks(0, 3, "default_div");
        cfg(0, 7, 0);
        step(30);
        cfg(0, 1, 0);
        tick_cnt[0] = 0;
        step(5);
        expect_ticks(0, 5, "div1");
        cfg(0, 0, 0);
        tick_cnt[0] = 0;
        step(10);
        expect_ticks(0, 0, "div0");
        cfg(1, 4, 1);
        tick_cnt[1] = 0;
        step(60);
        expect_ticks(1, 1, "oneshot");
        pulse_restart(1);
        step(10);
        expect_ticks(1, 2, "oneshot_rearm");
        cfg(2, 8, 0);
        step(3);
        en = 0;
        step(6);
        en = 1;
        step(20);
        restart[2] = 1;
        cfg(2, 5, 0);
        restart = '0;
        step(4);
        pulse_restart(2);
        step(12);
        cfg(N, 3, 1);
        step(4);
        cfg(3, 6, 0);
        step(5);
        for (int k = 0; k < 4; k++) begin
            cfg(0, 2 + k, k[0]);
            step(3);
        end
        step(4);
        rst = 1;
        step(1);
        rst = 0;
        tick_cnt[0] = 0;
        step(25);
        expect_ticks(0, 2, "reset_midrun");
        for (int k = 0; k < 500; k++) begin
            en = $urandom_range(0, 9) != 0;
            for (int i = 0; i < N; i++) restart[i] = $urandom_range(0, 15) == 0;
            cfg_we = $urandom_range(0, 9) == 0;
            cfg_ch = CHW'($urandom_range(0, 7));
            cfg_div = W'($urandom_range(0, 12));
            cfg_oneshot = $urandom_range(0, 3) == 0;
            step(1);
        end
        cfg_we = 0;
        restart = '0;
        en = 1;
        step(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
